// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer
//   Records (pc, data, timestamp) samples into an on-chip FIFO whenever the
//   probed pc/data pair changes. Detects a stalled pc and stops capturing.
//   The buffer can still be drained by a debug reader after a halt.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   capture_en  qualifies sampling this cycle
//   pc_in       probed program counter
//   data_in     probed ALU result
//   rd_en       pop request
//   rd_valid    rd_* carry a popped entry this cycle
//   rd_pc       popped pc
//   rd_data     popped data
//   rd_ts       popped timestamp
//   count       current occupancy
//   empty       count == 0
//   full        count == DEPTH
//   overflow    sticky: a qualified sample was lost or overwritten
//   halted      sticky: stall detected, capture stopped until reset
//
// Build option:
//   TRACE_WRAP_EN  when defined, a push into a full buffer overwrites the
//                  oldest entry. When undefined, the new sample is dropped.
module trace_capture_buffer #(
  parameter int PC_W        = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int TS_W        = 16,
  parameter int STALL_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic [PC_W-1:0]          pc_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int EW = PC_W + DATA_W + TS_W;

  typedef enum logic [1:0] {ARMED, RUN, HALTED} state_t;

  state_t             state_reg, state_next;
  logic [SW-1:0]      stall_reg, stall_next;
  logic [PC_W-1:0]    last_pc_reg, last_pc_next;
  logic [DATA_W-1:0]  last_data_reg, last_data_next;
  logic [TS_W-1:0]    ts_reg;
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic               overflow_reg;
  logic               rd_valid_reg;
  logic [PC_W-1:0]    rd_pc_reg;
  logic [DATA_W-1:0]  rd_data_reg;
  logic [TS_W-1:0]    rd_ts_reg;

  logic [EW-1:0]      mem [DEPTH];

  logic record, pop, push, drop, is_full, rd_adv, count_up, count_down;

  // Capture FSM: decides whether this cycle's sample is recorded and
  // tracks how long the pc has stayed put.
  always_comb begin
    state_next     = state_reg;
    stall_next     = stall_reg;
    last_pc_next   = last_pc_reg;
    last_data_next = last_data_reg;
    record         = 1'b0;
    case (state_reg)
      ARMED: begin
        if (capture_en) begin
          record         = 1'b1;
          last_pc_next   = pc_in;
          last_data_next = data_in;
          state_next     = RUN;
        end
      end
      RUN: begin
        if (capture_en) begin
          record         = (pc_in != last_pc_reg) || (data_in != last_data_reg);
          last_pc_next   = pc_in;
          last_data_next = data_in;
          if (pc_in == last_pc_reg) begin
            stall_next = stall_reg + SW'(1);
            // Reaching the limit on this cycle halts; the sample itself
            // is still recorded above if it changed.
            if (stall_reg == SW'(STALL_LIMIT - 1)) begin
              state_next = HALTED;
            end
          end else begin
            stall_next = '0;
          end
        end
      end
      HALTED: begin
      end
      default: state_next = ARMED;
    endcase
  end

  // FIFO control. A pop in the same cycle frees a slot, so a full buffer
  // only loses data when there is no simultaneous pop.
  always_comb begin
    is_full = (count_reg == CW'(DEPTH));
    pop     = rd_en && (count_reg != '0);
    drop    = record && is_full && !pop;
`ifdef TRACE_WRAP_EN
    push    = record;
    rd_adv  = pop || drop;   // overwrite: oldest entry is discarded
`else
    push    = record && !drop;
    rd_adv  = pop;
`endif
    count_up   = push && !pop && !is_full;
    count_down = pop && !push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ARMED;
      stall_reg     <= '0;
      last_pc_reg   <= '0;
      last_data_reg <= '0;
      ts_reg        <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_pc_reg     <= '0;
      rd_data_reg   <= '0;
      rd_ts_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      stall_reg     <= stall_next;
      last_pc_reg   <= last_pc_next;
      last_data_reg <= last_data_next;
      ts_reg        <= ts_reg + TS_W'(1);
      if (push)   wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_adv) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (count_up) begin
        count_reg <= count_reg + CW'(1);
      end else if (count_down) begin
        count_reg <= count_reg - CW'(1);
      end
      if (drop) overflow_reg <= 1'b1;
      rd_valid_reg <= pop;
      // Registered read; when a full buffer pushes and pops together the
      // pointers coincide and this picks up the old entry before the write.
      if (pop) begin
        rd_pc_reg   <= mem[rd_ptr_reg][EW-1 -: PC_W];
        rd_data_reg <= mem[rd_ptr_reg][TS_W +: DATA_W];
        rd_ts_reg   <= mem[rd_ptr_reg][TS_W-1:0];
      end
    end
  end

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr_reg] <= {pc_in, data_in, ts_reg};
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_pc    = rd_pc_reg;
  assign rd_data  = rd_data_reg;
  assign rd_ts    = rd_ts_reg;
  assign count    = count_reg;
  assign empty    = (count_reg == '0);
  assign full     = is_full;
  assign overflow = overflow_reg;
  assign halted   = (state_reg == HALTED);

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Synthesizable successor to the simulation-only PC/ALU-result monitor; records (pc, data, timestamp) samples into an on-chip FIFO only when the sampled pair changes.
- Parametrised in widths, depth and stall threshold.
- Sits beside the core top level, probing the core's PC and ALU result; drained by a debug reader over a simple read port.
- Adds stall/halt detection, replacing fixed-length simulation timeouts.

Parameters:
- PC_W, 32, width of pc_in
- DATA_W, 32, width of data_in
- DEPTH, 16, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp counter width
- STALL_LIMIT, 8, consecutive qualified cycles with unchanged pc that trigger halt; >= 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- capture_en  in  1  qualifies sampling this cycle
- pc_in  in  PC_W  probed program counter
- data_in  in  DATA_W  probed ALU result
- rd_en  in  1  pop request
- rd_valid  out  1  rd_* outputs valid this cycle
- rd_pc  out  PC_W  popped pc
- rd_data  out  DATA_W  popped data
- rd_ts  out  TS_W  popped timestamp
- count  out  $clog2(DEPTH)+1  current occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky; a qualified sample was lost or overwritten
- halted  out  1  sticky; stall detected, capture stopped

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset (rd_en ignored in the reset cycle): rd_valid=0, rd_pc/rd_data/rd_ts=0, count=0, empty=1, full=0, overflow=0, halted=0, timestamp=0, state=ARMED; any in-flight data is discarded.
- Timestamp: free-running TS_W counter, +1 per cycle from reset, wraps 2^TS_W-1 -> 0. A sample stores the counter value of its capture cycle.
- States:
  - ARMED: the first cycle with capture_en=1 always records, latches last_pc/last_data, then moves to RUN.
  - RUN: on capture_en=1, records if pc_in != last_pc OR data_in != last_data, then updates last_*.
  - HALTED: no capture; exits only via reset.
- Stall counter:
  - In RUN, on each capture_en=1 cycle, increments if pc_in == last_pc and clears otherwise.
  - Holds when capture_en=0.
  - On reaching STALL_LIMIT, moves to HALTED and sets halted the next cycle.
  - The sample in the triggering cycle is still recorded if it qualifies.
- Write when full (macro absent): the sample is dropped and overflow is set.
- Read:
  - rd_en=1 and !empty: pops the oldest entry; rd_* are registered and rd_valid=1 the next cycle (latency 1).
  - rd_en with empty: no pop, rd_valid=0, no error.
  - rd_* hold their last value when rd_valid=0.
- Simultaneous push and pop:
  - When full: both succeed, count unchanged, no overflow.
  - When empty: the pop is ignored and the push succeeds.
- Pointers: wrap modulo DEPTH.
- Status outputs: count, empty and full update one cycle after the push/pop.
- Reads remain allowed in HALTED, so the buffer can be drained after a halt.

Optional Feature:
- Macro: TRACE_WRAP_EN.
- Defined: a push when full, without a simultaneous pop, overwrites the oldest entry (read pointer advances with write). count stays DEPTH and overflow is set. The buffer then holds the latest DEPTH samples.
- Undefined: drop-newest behaviour as in Behaviour.

Test Plan:
- Reset then capture_en=1, pc_in=0x00, data_in=0x5 held for 1 cycle -> exactly one entry. Pop it -> rd_valid=1 one cycle after rd_en, with rd_pc=0x00, rd_data=0x5, rd_ts equal to the capture-cycle counter value.
- pc 0x00,0x04,0x04,0x08 with data 1,2,2,3 on consecutive enabled cycles -> 3 entries (0x00/1, 0x04/2, 0x08/3); duplicate not stored.
- DEPTH=16: 20 distinct samples without reads.
  - Macro absent -> count=16, overflow=1, pops return samples 0..15.
  - TRACE_WRAP_EN defined -> pops return samples 4..19.
- pc held at 0x40 for 8 enabled cycles after RUN (STALL_LIMIT=8) -> halted=1. Later pc changes are not recorded. Drain still returns the stored entries in order.
- Full buffer with rd_en=1 and a new distinct sample in the same cycle -> count stays 16, overflow stays 0, oldest entry popped.
- Reset asserted mid-drain with count=5 -> next cycle count=0, empty=1, rd_valid=0, halted=0, timestamp=0. The next enabled sample is recorded unconditionally (ARMED).
